// File: rtl/vending_machine_param.sv
// Parametrised single-product vending controller with serial unit-coin change return.
// Optional refund request input is enabled by defining VEND_CANCEL_EN.
module vending_machine_param #(
  parameter int CREDIT_W    = 8,
  parameter int PRICE       = 40,
  parameter int COIN0       = 10,
  parameter int COIN1       = 20,
  parameter int COIN2       = 50,
  parameter int COIN3       = 100,
  parameter int CHANGE_UNIT = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_in,
`ifdef VEND_CANCEL_EN
  input  logic                cancel,
`endif
  output logic                machine_out,
  output logic                change_coin,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] VEND   = 2'd2;
  localparam logic [1:0] CHANGE = 2'd3;

  localparam logic [CREDIT_W:0]   PRICE_W = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] UNIT_W  = CREDIT_W'(CHANGE_UNIT);
  localparam logic [CREDIT_W-1:0] ZERO_W  = CREDIT_W'(0);

  logic [1:0]          state_r;
  logic [CREDIT_W-1:0] credit_r;
  logic [1:0]          next_state_s;
  logic [CREDIT_W-1:0] next_credit_s;
  logic [CREDIT_W-1:0] coin_val_s;
  logic [CREDIT_W:0]   sum_s;
  logic                reject_s;
  logic                cancel_hit_s;

  // Cancel only acts while credit is being accumulated.
`ifdef VEND_CANCEL_EN
  assign cancel_hit_s = cancel & (state_r == ACCUM);
`else
  assign cancel_hit_s = 1'b0;
`endif

  // Coin code to credit value lookup.
  always_comb begin
    case (coin_in)
      2'b00:   coin_val_s = CREDIT_W'(COIN0);
      2'b01:   coin_val_s = CREDIT_W'(COIN1);
      2'b10:   coin_val_s = CREDIT_W'(COIN2);
      2'b11:   coin_val_s = CREDIT_W'(COIN3);
      default: coin_val_s = ZERO_W;
    endcase
  end

  assign sum_s = {1'b0, credit_r} + {1'b0, coin_val_s};

  // Next-state, next-credit and coin rejection decision.
  always_comb begin
    next_state_s  = state_r;
    next_credit_s = credit_r;
    reject_s      = 1'b0;
    case (state_r)
      IDLE, ACCUM: begin
        if (cancel_hit_s) begin
          next_state_s = CHANGE;
          reject_s     = coin_valid;
        end else if (coin_valid) begin
          if (sum_s < PRICE_W) begin
            next_credit_s = CREDIT_W'(sum_s);
            next_state_s  = ACCUM;
          end else begin
            next_credit_s = CREDIT_W'(sum_s - PRICE_W);
            next_state_s  = VEND;
          end
        end else begin
          next_state_s = state_r;
        end
      end
      VEND: begin
        reject_s = coin_valid;
        if (credit_r != ZERO_W) begin
          next_state_s = CHANGE;
        end else begin
          next_state_s = IDLE;
        end
      end
      CHANGE: begin
        reject_s = coin_valid;
        // The last unit coin leaves on this edge; fall back to IDLE with zero credit.
        if (credit_r <= UNIT_W) begin
          next_credit_s = ZERO_W;
          next_state_s  = IDLE;
        end else begin
          next_credit_s = credit_r - UNIT_W;
          next_state_s  = CHANGE;
        end
      end
      default: begin
        next_state_s  = IDLE;
        next_credit_s = ZERO_W;
      end
    endcase
  end

  // State, credit and registered output flops, decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      credit_r    <= ZERO_W;
      machine_out <= 1'b0;
      change_coin <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      credit_r    <= next_credit_s;
      machine_out <= (next_state_s == VEND);
      change_coin <= (next_state_s == CHANGE);
      coin_reject <= reject_s;
      busy        <= (next_state_s == VEND) || (next_state_s == CHANGE);
    end
  end

  assign credit = credit_r;

endmodule
